// File: rtl/obi_rd_initiator.sv
// Read-only bridge from an OBI read port to a simple AR/R read channel. It limits
// outstanding reads, registers both paths and fails stuck reads via a watchdog.
module obi_rd_initiator #(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned TIMEOUT_CYCLES  = 256,
   parameter logic [31:0] ERR_RDATA       = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        obi_req,
   output logic        obi_gnt,
   input  logic [31:0] obi_addr,
   output logic        obi_rvalid,
   output logic [31:0] obi_rdata,
   output logic        obi_err,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic        rvalid,
   output logic        rready,
   output logic        busy,
   output logic        timeout_pulse
);

   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_OUTSTANDING);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] issued_q, issued_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          arvalid_q, arvalid_d;
   logic [31:0]   araddr_q, araddr_d;
   logic          obi_rvalid_q, obi_rvalid_d;
   logic          obi_err_q, obi_err_d;
   logic [31:0]   obi_rdata_q, obi_rdata_d;
   logic          timeout_q, timeout_d;

   logic ar_fire;
   logic resp_fire;
   logic drop_fire;
   logic timeout_fire;

   // A new grant needs a free outstanding slot and an AR stage that is empty or draining.
   assign obi_gnt = obi_req && (outstanding_q < MAX_CNT) && (!arvalid_q || arready);

   assign ar_fire   = arvalid_q && arready;
   assign drop_fire = rvalid && (drop_q != '0);
   assign resp_fire = rvalid && (drop_q == '0) && (issued_q != '0);

   // A beat landing in the expiry cycle is served normally and suppresses the timeout.
   assign timeout_fire = (issued_q != '0) && (timer_q == TIMER_LAST) && !resp_fire;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      arvalid_d = arvalid_q;
      araddr_d  = araddr_q;
      if (obi_gnt) begin
         arvalid_d = 1'b1;
         araddr_d  = obi_addr & 32'hFFFF_FFFC;
      end else if (ar_fire) begin
         arvalid_d = 1'b0;
      end
   end

   always_comb begin
      outstanding_d = outstanding_q;
      if (obi_gnt && !obi_rvalid_q) begin
         outstanding_d = outstanding_q + CW'(1);
      end else if (!obi_gnt && obi_rvalid_q) begin
         outstanding_d = outstanding_q - CW'(1);
      end
   end

   always_comb begin
      issued_d = issued_q;
      if (ar_fire && !(resp_fire || timeout_fire)) begin
         issued_d = issued_q + CW'(1);
      end else if (!ar_fire && (resp_fire || timeout_fire)) begin
         issued_d = issued_q - CW'(1);
      end
   end

   // Late beats owed to timed-out reads are swallowed; the count saturates at the slot limit.
   always_comb begin
      drop_d = drop_q;
      if (timeout_fire && !drop_fire) begin
         if (drop_q != MAX_CNT) begin
            drop_d = drop_q + CW'(1);
         end
      end else if (!timeout_fire && drop_fire) begin
         drop_d = drop_q - CW'(1);
      end
   end

   always_comb begin
      timer_d = timer_q + TW'(1);
      if ((issued_q == '0) || resp_fire || timeout_fire) begin
         timer_d = '0;
      end
   end

   always_comb begin
      obi_rvalid_d = resp_fire || timeout_fire;
      obi_err_d    = timeout_fire;
      timeout_d    = timeout_fire;
      obi_rdata_d  = obi_rdata_q;
      if (resp_fire) begin
         obi_rdata_d = rdata;
      end else if (timeout_fire) begin
         obi_rdata_d = ERR_RDATA;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding_q <= '0;
         issued_q      <= '0;
         drop_q        <= '0;
         timer_q       <= '0;
         arvalid_q     <= 1'b0;
         araddr_q      <= '0;
         obi_rvalid_q  <= 1'b0;
         obi_err_q     <= 1'b0;
         obi_rdata_q   <= '0;
         timeout_q     <= 1'b0;
      end else begin
         outstanding_q <= outstanding_d;
         issued_q      <= issued_d;
         drop_q        <= drop_d;
         timer_q       <= timer_d;
         arvalid_q     <= arvalid_d;
         araddr_q      <= araddr_d;
         obi_rvalid_q  <= obi_rvalid_d;
         obi_err_q     <= obi_err_d;
         obi_rdata_q   <= obi_rdata_d;
         timeout_q     <= timeout_d;
      end
   end

   // OBI has no response backpressure, so the R channel is always accepted.
   assign rready        = 1'b1;
   assign arvalid       = arvalid_q;
   assign araddr        = araddr_q;
   assign obi_rvalid    = obi_rvalid_q;
   assign obi_err       = obi_err_q;
   assign obi_rdata     = obi_rdata_q;
   assign timeout_pulse = timeout_q;
   assign busy          = (outstanding_q != '0) || (drop_q != '0);

endmodule
